// File: rtl/sdr_pkg.sv
// Shared definitions for the SDR control path: formatter FSM state
// encoding and the ASCII constants used when printing decimal values.
package sdr_pkg;

    // Formatter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CONVERT = 3'd1,
        ST_EMIT    = 3'd2,
        ST_TERM_CR = 3'd3,
        ST_TERM_LF = 3'd4
    } fmt_state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Map a BCD digit (0..9) onto its ASCII character.
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter (shift-and-add-3). One input bit is
// consumed per asserted step. 'done' is high during the step that consumes
// the final bit, so the caller can leave its convert state on that same
// edge and see the finished BCD value on the following cycle.
module bcd_double_dabble #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  step,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    shift_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [CNT_W-1:0]    count_q;

    logic [4*DIGITS-1:0] bcd_adj;
    logic [4*DIGITS-1:0] bcd_next;
    logic [WIDTH-1:0]    shift_next;

    // Add 3 to every nibble >= 5, then shift {bcd, shift} left by one bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            else
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
        end
        bcd_next   = {bcd_adj[4*DIGITS-2:0], shift_q[WIDTH-1]};
        shift_next = {shift_q[WIDTH-2:0], 1'b0};
    end

    // Conversion registers: load seeds the operand, step advances one bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            shift_q <= '0;
            bcd_q   <= '0;
            count_q <= '0;
        end else if (load) begin
            shift_q <= data_in;
            bcd_q   <= '0;
            count_q <= CNT_W'(WIDTH);
        end else if (step && (count_q != '0)) begin
            shift_q <= shift_next;
            bcd_q   <= bcd_next;
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign done = step && (count_q == CNT_W'(1));
    assign bcd  = bcd_q;

endmodule

// File: rtl/freq_ascii_fmt.sv
// Frequency word to decimal ASCII formatter. Converts freq_in to BCD,
// then writes the significant digits followed by CR LF into the UART TX
// FIFO, stalling on tx_fifo_full so no character is ever dropped.
module freq_ascii_fmt
    import sdr_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] freq_in,
    input  logic             start,
    output logic             busy,
    output logic [7:0]       tx_data,
    output logic             tx_fifo_wr,
    input  logic             tx_fifo_full,
    output logic             done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    fmt_state_t          state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                seen_nz_q;
    logic                done_q;

    logic                dd_load;
    logic                dd_step;
    logic                dd_done;
    logic [4*DIGITS-1:0] bcd;

    logic [3:0]          cur_digit;
    logic                skip;
    logic                emit_wr;

    assign dd_load = (state_q == ST_IDLE) && start;
    assign dd_step = (state_q == ST_CONVERT);

    bcd_double_dabble #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (dd_load),
        .data_in (freq_in),
        .step    (dd_step),
        .done    (dd_done),
        .bcd     (bcd)
    );

    // Select the BCD digit addressed by the emit index.
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i))
                cur_digit = bcd[4*i +: 4];
        end
    end

    // Digit 0 is never skipped, so a zero value still prints "0".
    assign skip    = (cur_digit == 4'h0) && !seen_nz_q && (idx_q != '0);
    assign emit_wr = (state_q == ST_EMIT) && !skip;

    assign tx_fifo_wr = (emit_wr || (state_q == ST_TERM_CR) || (state_q == ST_TERM_LF))
                        && !tx_fifo_full;

    // Output byte depends only on registered state, so it holds during a stall.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            ST_EMIT:    tx_data = digit_to_ascii(cur_digit);
            ST_TERM_CR: tx_data = ASCII_CR;
            ST_TERM_LF: tx_data = ASCII_LF;
            default:    tx_data = 8'h00;
        endcase
    end

    // Control FSM: accept, wait for conversion, emit digits, terminate line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            seen_nz_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start)
                        state_q <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (dd_done) begin
                        state_q   <= ST_EMIT;
                        idx_q     <= IDX_W'(DIGITS - 1);
                        seen_nz_q <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (skip) begin
                        idx_q <= idx_q - IDX_W'(1);
                    end else if (!tx_fifo_full) begin
                        seen_nz_q <= 1'b1;
                        if (idx_q == '0)
                            state_q <= ST_TERM_CR;
                        else
                            idx_q <= idx_q - IDX_W'(1);
                    end
                end
                ST_TERM_CR: begin
                    if (!tx_fifo_full)
                        state_q <= ST_TERM_LF;
                end
                ST_TERM_LF: begin
                    if (!tx_fifo_full) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_freq_ascii_fmt.sv
// Self-checking bench for freq_ascii_fmt: directed corner cases plus
// randomized values with random FIFO back-pressure, checked against a
// decimal-string reference model.
module tb_freq_ascii_fmt;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] freq_in = '0;
    logic             start = 1'b0;
    logic             tx_fifo_full = 1'b0;
    logic             busy;
    logic [7:0]       tx_data;
    logic             tx_fifo_wr;
    logic             done;

    freq_ascii_fmt #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .freq_in      (freq_in),
        .start        (start),
        .busy         (busy),
        .tx_data      (tx_data),
        .tx_fifo_wr   (tx_fifo_wr),
        .tx_fifo_full (tx_fifo_full),
        .done         (done)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Monitor: captures every FIFO write and done pulse on the falling edge.
    int         ncyc = 0;
    int         accept_n = 0;
    int         first_rel = -1;
    int         done_rel = -1;
    int         done_cnt = 0;
    int         viol = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         exp_ndig = 0;

    always @(negedge clk) begin
        ncyc++;
        if (tx_fifo_wr === 1'b1) begin
            got_q.push_back(tx_data);
            if (first_rel < 0) first_rel = ncyc - accept_n;
            if (tx_fifo_full) viol++;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_rel = ncyc - accept_n;
        end
    end

    // Reference model: decimal digits by repeated division, then CR LF.
    task automatic build_exp(input logic [WIDTH-1:0] v);
        longint unsigned x;
        logic [7:0] digs[$];
        x = v;
        do begin
            digs.push_front(8'(8'h30 + (x % 10)));
            x = x / 10;
        end while (x != 0);
        exp_ndig = digs.size();
        exp_q = digs;
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic launch(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        freq_in   = v;
        start     = 1'b1;
        got_q.delete();
        first_rel = -1;
        done_rel  = -1;
        done_cnt  = 0;
        @(posedge clk);
        accept_n = ncyc;
        #1;
        start   = 1'b0;
        freq_in = $urandom;
        @(negedge clk); #1;
        check("busy_rise", busy, 1);
    endtask

    task automatic finish(input logic [WIDTH-1:0] v, input bit stall, input bit timing);
        build_exp(v);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk); #1;
            if (done_cnt != 0) break;
            @(posedge clk); #1;
            tx_fifo_full = stall ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        tx_fifo_full = 1'b0;
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (3) @(negedge clk);
        #1;
        check("busy_fall", busy, 0);
        check("done_once", done_cnt, 1);
        check("byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check($sformatf("byte%0d", i), got_q[i], exp_q[i]);
        if (timing) begin
            check("first_wr_edge", first_rel, WIDTH + 1 + (DIGITS - exp_ndig));
            check("skip_cycles", first_rel - (WIDTH + 1), DIGITS - exp_ndig);
            check("done_edge", done_rel - 1, WIDTH + (DIGITS - exp_ndig) + exp_ndig + 2);
        end
    endtask

    task automatic wait_writes(input int n);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (got_q.size() >= n) break;
        end
        if (got_q.size() < n) check("wait_writes_timeout", got_q.size(), n);
    endtask

    initial begin
        int nsaved;
        logic [WIDTH-1:0] v;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wr", tx_fifo_wr, 0);
        check("rst_data", tx_data, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic value, zero and maximum
        launch(32'd515396076);
        finish(32'd515396076, 0, 1);
        launch(32'd0);
        finish(32'd0, 0, 1);
        launch(32'hFFFFFFFF);
        finish(32'hFFFFFFFF, 0, 1);

        // Back-pressure mid-digit on "108"
        build_exp(32'd108);
        launch(32'd108);
        wait_writes(1);
        @(posedge clk); #1;
        tx_fifo_full = 1'b1;
        repeat (5) begin
            @(negedge clk); #1;
            check("stall_no_wr", tx_fifo_wr, 0);
            check("stall_hold", tx_data, exp_q[1]);
        end
        check("stall_cnt", got_q.size(), 1);
        @(posedge clk); #1;
        tx_fifo_full = 1'b0;
        finish(32'd108, 0, 0);

        // Second start during CONVERT is ignored
        launch(32'd4000000001);
        repeat (5) @(posedge clk);
        #1;
        freq_in = 32'd77;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish(32'd4000000001, 0, 1);

        // Reset pulsed during EMIT aborts the line
        launch(32'd987654321);
        wait_writes(3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr", tx_fifo_wr, 0);
        check("abort_data", tx_data, 0);
        check("abort_done", done, 0);
        nsaved = got_q.size();
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_writes", got_q.size(), nsaved);
        check("abort_no_done", done_cnt, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        launch(32'd123456);
        finish(32'd123456, 0, 1);

        // Randomized values, alternating random back-pressure
        for (int i = 0; i < 12; i++) begin
            v = $urandom >> $urandom_range(0, 31);
            launch(v);
            finish(v, (i % 2) == 1, (i % 2) == 0);
        end

        check("no_wr_while_full", viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
